// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot state encodings, default frame geometry and
// a constant clog2 helper, used by both the transmitter and the receiver.
package uart_pkg;

    localparam int NUM_TICKS_DEF     = 16;
    localparam int BITS_PER_DATA_DEF = 8;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } uart_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter with a programmable terminal count; bit_end marks
// the tick on which the current serial bit finishes.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CNT_W = clog2(NUM_TICKS_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             clear,
    input  logic [CNT_W-1:0] term,
    output logic             bit_end
);

    logic [CNT_W-1:0] s_r;

    assign bit_end = tick && (s_r == term);

    // Tick counter: clear dominates, wraps to zero at the terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            s_r <= {CNT_W{1'b0}};
        end else if (bit_end) begin
            s_r <= {CNT_W{1'b0}};
        end else if (tick) begin
            s_r <= s_r + CNT_W'(1);
        end else begin
            s_r <= s_r;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, LSB-first data, optional even parity, 1-3 stop bits.
// Define UART_TX_PARITY_EN to build the parity bit; otherwise 'parity' is ignored.
module uart_tx
    import uart_pkg::*;
#(
    parameter int NUM_TICKS     = NUM_TICKS_DEF,
    parameter int BITS_PER_DATA = BITS_PER_DATA_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     tx_start,
    input  logic [BITS_PER_DATA-1:0] d_in,
    input  logic                     parity,
    input  logic [1:0]               stop_bits,
    output logic                     tx,
    output logic                     tx_busy,
    output logic                     tx_done
);

    localparam int TW = clog2(NUM_TICKS);
    localparam int NW = (clog2(BITS_PER_DATA) < 2) ? 2 : clog2(BITS_PER_DATA);

    function automatic logic even_parity(input logic [BITS_PER_DATA-1:0] value);
        return ^value;
    endfunction

    uart_state_t              state_r, state_s;
    logic [BITS_PER_DATA-1:0] shift_r, shift_s;
    logic [NW-1:0]            n_r, n_s;
    logic [1:0]               sb_r, sb_s;
    logic                     tx_r, tx_s;
    logic                     busy_r, busy_s;
    logic                     done_r, done_s;
    logic                     bit_end_s;
    logic                     timer_clear_s;

`ifdef UART_TX_PARITY_EN
    logic                     par_r, par_s;
    logic [BITS_PER_DATA-1:0] data_r, data_s;
`else
    logic                     parity_unused_s;
    assign parity_unused_s = parity;
`endif

    // Timer is held at zero while idle so a tick coinciding with the accept is not counted.
    assign timer_clear_s = (state_r == IDLE);

    uart_bit_timer #(
        .CNT_W (TW)
    ) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .clear   (timer_clear_s),
        .term    (TW'(NUM_TICKS - 1)),
        .bit_end (bit_end_s)
    );

    // Next-state and next-output logic; outputs are derived from next state so tx is a pure flop.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        n_s     = n_r;
        sb_s    = sb_r;
        done_s  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_s   = par_r;
        data_s  = data_r;
`endif
        case (state_r)
            IDLE: begin
                // done_r blocks a request in the same clk the previous frame completes
                if (tx_start && !done_r) begin
                    shift_s = d_in;
                    n_s     = {NW{1'b0}};
                    sb_s    = (stop_bits == 2'd0) ? 2'd1 : stop_bits;
`ifdef UART_TX_PARITY_EN
                    par_s   = parity;
                    data_s  = d_in;
`endif
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (bit_end_s) begin
                    n_s     = {NW{1'b0}};
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_s = shift_r >> 1;
                    if (n_r == NW'(BITS_PER_DATA - 1)) begin
                        n_s = {NW{1'b0}};
`ifdef UART_TX_PARITY_EN
                        state_s = par_r ? PARITY : STOP;
`else
                        state_s = STOP;
`endif
                    end else begin
                        n_s = n_r + NW'(1);
                    end
                end else begin
                    state_s = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end_s) begin
                    n_s     = {NW{1'b0}};
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (bit_end_s) begin
                    if ((n_r + NW'(1)) == NW'(sb_r)) begin
                        n_s     = {NW{1'b0}};
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        n_s = n_r + NW'(1);
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                n_s     = {NW{1'b0}};
                state_s = IDLE;
            end
        endcase

        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_s = even_parity(data_s);
`endif
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase

        busy_s = (state_s != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            shift_r <= {BITS_PER_DATA{1'b0}};
            n_r     <= {NW{1'b0}};
            sb_r    <= 2'd0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_r   <= 1'b0;
            data_r  <= {BITS_PER_DATA{1'b0}};
`endif
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            n_r     <= n_s;
            sb_r    <= sb_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
`ifdef UART_TX_PARITY_EN
            par_r   <= par_s;
            data_r  <= data_s;
`endif
        end
    end

    assign tx      = tx_r;
    assign tx_busy = busy_r;
    assign tx_done = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frames are captured by sampling tx mid-bit and
// compared with hand-computed bit patterns and frame lengths in ticks.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       tx_start;
    logic [7:0] d_in;
    logic       parity;
    logic [1:0] stop_bits;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .tx_start  (tx_start),
        .d_in      (d_in),
        .parity    (parity),
        .stop_bits (stop_bits),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive tick, then advance to the next negedge.
    task automatic step(input logic tk);
        tick = tk;
        @(negedge clk);
    endtask

    // Count ticks after accept, sample tx at tick 8 of each bit, stop at tx_done or stop_at ticks.
    task automatic capture(input int stop_at, input bit wiggle,
                           output logic [15:0] bits, output int dtick);
        int   tcnt;
        logic tk;
        tcnt  = 0;
        tk    = 1'b0;
        bits  = 16'h0000;
        dtick = -1;
        for (int c = 0; c < 4000; c++) begin
            step(tk);
            if (tk) tcnt++;
            if (tk && (tcnt % 16 == 8) && (tcnt / 16 < 16)) bits[tcnt / 16] = tx;
            if (wiggle) d_in = d_in + 8'd1;
            if (tx_done) begin
                dtick = tcnt;
                break;
            end
            if (stop_at > 0 && tcnt == stop_at) break;
            tk = ~tk;
        end
        if (stop_at == 0 && dtick < 0) check_val("timeout", 32'd0, 32'd1);
    endtask

    // Send one byte (accept clk carries a tick) and check the whole frame.
    task automatic run_frame(input string tag, input logic [7:0] d, input logic p,
                             input logic [1:0] sb, input logic [15:0] exp_bits, input int exp_tick);
        logic [15:0] bits;
        int          dt;
        d_in      = d;
        parity    = p;
        stop_bits = sb;
        tx_start  = 1'b1;
        step(1'b1);
        tx_start  = 1'b0;
        check_val({tag, "_acc_tx"}, tx, 0);
        check_val({tag, "_acc_busy"}, tx_busy, 1);
        capture(0, 1'b0, bits, dt);
        check_val({tag, "_bits"}, bits, exp_bits);
        check_val({tag, "_ticks"}, dt, exp_tick);
        check_val({tag, "_busy_at_done"}, tx_busy, 0);
        step(1'b0);
        check_val({tag, "_done_pulse"}, tx_done, 0);
        check_val({tag, "_idle_tx"}, tx, 1);
    endtask

    initial begin
        logic [15:0] bits;
        int          dt;
        reset     = 1'b1;
        tick      = 1'b0;
        tx_start  = 1'b0;
        d_in      = 8'h00;
        parity    = 1'b0;
        stop_bits = 2'd1;
        repeat (3) @(negedge clk);
        check_val("rst_tx", tx, 1);
        check_val("rst_busy", tx_busy, 0);
        check_val("rst_done", tx_done, 0);
        reset = 1'b0;
        @(negedge clk);

        // A5, 8N1: 0,1,0,1,0,0,1,0,1,1
        run_frame("a5", 8'hA5, 1'b0, 2'd1, 16'h034A, 160);

        // Parity: 07 -> parity 1, 03 -> parity 0
        if (PAR_ON) begin
            run_frame("p07", 8'h07, 1'b1, 2'd1, 16'h060E, 176);
            run_frame("p03", 8'h03, 1'b1, 2'd1, 16'h0406, 176);
        end else begin
            run_frame("p07", 8'h07, 1'b1, 2'd1, 16'h020E, 160);
            run_frame("p03", 8'h03, 1'b1, 2'd1, 16'h0206, 160);
        end

        // Stop bit counts 2, 0 (treated as 1), 3
        run_frame("sb2", 8'h00, 1'b0, 2'd2, 16'h0600, 176);
        run_frame("sb0", 8'h00, 1'b0, 2'd0, 16'h0200, 160);
        run_frame("sb3", 8'h00, 1'b0, 2'd3, 16'h0E00, 192);

        // tx_start held with d_in changing: only 5A is sent, retry ignored in the done clk
        d_in      = 8'h5A;
        parity    = 1'b0;
        stop_bits = 2'd1;
        tx_start  = 1'b1;
        step(1'b1);
        check_val("hold_acc_tx", tx, 0);
        capture(0, 1'b1, bits, dt);
        check_val("hold_bits", bits, 16'h02B4);
        check_val("hold_ticks", dt, 160);
        d_in = 8'hC3;
        step(1'b0);
        check_val("hold_ign_tx", tx, 1);
        check_val("hold_ign_busy", tx_busy, 0);
        check_val("hold_ign_done", tx_done, 0);
        step(1'b0);
        check_val("hold_next_tx", tx, 0);
        check_val("hold_next_busy", tx_busy, 1);
        tx_start = 1'b0;
        capture(0, 1'b0, bits, dt);
        check_val("hold2_bits", bits, 16'h0386);
        check_val("hold2_ticks", dt, 160);
        step(1'b0);

        // Reset at tick 50 (inside data bit 2 of 00, tx low) aborts at once
        d_in     = 8'h00;
        tx_start = 1'b1;
        step(1'b1);
        tx_start = 1'b0;
        capture(50, 1'b0, bits, dt);
        check_val("pre_rst_tx", tx, 0);
        reset = 1'b1;
        #1;
        check_val("mid_rst_tx", tx, 1);
        check_val("mid_rst_busy", tx_busy, 0);
        check_val("mid_rst_done", tx_done, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_frame("post_rst_3c", 8'h3C, 1'b0, 2'd1, 16'h0278, 160);

        // Random bytes, parity and stop counts against a small frame model
        for (int k = 0; k < 20; k++) begin
            logic [7:0]  rd;
            logic        rp;
            logic [1:0]  rsb;
            logic [15:0] eb;
            int          idx;
            int          nsb;
            rd  = 8'($urandom_range(255, 0));
            rp  = 1'($urandom_range(1, 0));
            rsb = 2'($urandom_range(3, 0));
            eb  = 16'h0000;
            idx = 1;
            for (int i = 0; i < 8; i++) begin
                eb[idx] = rd[i];
                idx++;
            end
            if (PAR_ON && rp) begin
                eb[idx] = ^rd;
                idx++;
            end
            nsb = (rsb == 2'd0) ? 1 : int'(rsb);
            for (int i = 0; i < nsb; i++) begin
                eb[idx] = 1'b1;
                idx++;
            end
            run_frame("rand", rd, rp, rsb, eb, idx * 16);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
